// File: rtl/seqdetect_pkg.sv
// Shared types and constants for the "00111100" detector and its scan controller.
package seqdetect_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWaitWord,
    StShift,
    StDrain,
    StDone
  } scan_state_t;

  localparam logic [7:0]  SEQ_PATTERN = 8'b00111100;
  localparam int unsigned SEQ_LEN     = 8;

endpackage

// File: rtl/seqdetect_ser.sv
// MSB-first word serializer: shift register plus per-word bit counter.
module seqdetect_ser #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              msb_next_o,
  output logic              last_bit_o
);

  localparam int unsigned BitCntW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = word_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Next MSB lets the parent register det_din in step with the shift.
  assign msb_next_o = sr_d[WORD_W-1];
  assign last_bit_o = (cnt_q == BitCntW'(WORD_W - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seqdetect_scan.sv
// Scan controller: serializes a block of words into the seqdetect detector,
// counts rising edges of its flag and records the position of the first hit.
module seqdetect_scan
  import seqdetect_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned POS_W = LEN_W + $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  num_words,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              det_din,
  output logic              det_rst,
  input  logic              det_flag,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [POS_W-1:0]  first_hit_pos,
  output logic              hit_any,
  output logic              err_underrun
);

  scan_state_t       state_q, state_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [POS_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [POS_W-1:0]  first_hit_pos_q, first_hit_pos_d;
  logic              hit_any_q, hit_any_d;
  logic              err_underrun_q, err_underrun_d;
  logic              flag_q, flag_d;
  logic              det_din_q, det_din_d;
  logic              det_rst_q, det_rst_d;
  logic              load, shift, msb_next, last_bit, hit;

  seqdetect_ser #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .shift_i    (shift),
    .word_i     (word_data),
    .msb_next_o (msb_next),
    .last_bit_o (last_bit)
  );

  // The detector holds its flag for two cycles; only the rising edge is a hit.
  assign hit = det_flag & ~flag_q & ((state_q == StShift) | (state_q == StDrain));

  always_comb begin
    state_d         = state_q;
    words_left_d    = words_left_q;
    bit_idx_d       = bit_idx_q;
    hit_count_d     = hit_count_q;
    first_hit_pos_d = first_hit_pos_q;
    hit_any_d       = hit_any_q;
    err_underrun_d  = err_underrun_q;
    flag_d          = det_flag & ~det_rst_q;
    load            = 1'b0;
    word_ready      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          words_left_d = num_words;
          state_d      = StClear;
        end
      end
      StClear: begin
        hit_count_d     = '0;
        first_hit_pos_d = '0;
        hit_any_d       = 1'b0;
        err_underrun_d  = 1'b0;
        bit_idx_d       = '0;
        state_d         = (words_left_q == '0) ? StDone : StWaitWord;
      end
      StWaitWord: begin
        word_ready = 1'b1;
        if (word_valid) begin
          load         = 1'b1;
          words_left_d = words_left_q - 1'b1;
          state_d      = StShift;
        end
      end
      StShift: begin
        bit_idx_d = bit_idx_q + 1'b1;
        if (last_bit) begin
          word_ready = 1'b1;
          if (words_left_q == '0) begin
            state_d = StDrain;
          end else if (word_valid) begin
            load         = 1'b1;
            words_left_d = words_left_q - 1'b1;
          end else begin
            // Starvation ends the scan rather than stalling the bit stream.
            err_underrun_d = 1'b1;
            state_d        = StDrain;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (hit) begin
      if (hit_count_q != {CNT_W{1'b1}}) begin
        hit_count_d = hit_count_q + 1'b1;
      end
      if (!hit_any_q) begin
        hit_any_d       = 1'b1;
        first_hit_pos_d = bit_idx_q - 1'b1;
      end
    end
  end

  assign shift     = (state_q == StShift) & ~load;
  assign det_rst_d = ~((state_d == StShift) | (state_d == StDrain));
  assign det_din_d = (state_d == StShift) & msb_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      words_left_q    <= '0;
      bit_idx_q       <= '0;
      hit_count_q     <= '0;
      first_hit_pos_q <= '0;
      hit_any_q       <= 1'b0;
      err_underrun_q  <= 1'b0;
      flag_q          <= 1'b0;
      det_din_q       <= 1'b0;
      det_rst_q       <= 1'b1;
    end else begin
      state_q         <= state_d;
      words_left_q    <= words_left_d;
      bit_idx_q       <= bit_idx_d;
      hit_count_q     <= hit_count_d;
      first_hit_pos_q <= first_hit_pos_d;
      hit_any_q       <= hit_any_d;
      err_underrun_q  <= err_underrun_d;
      flag_q          <= flag_d;
      det_din_q       <= det_din_d;
      det_rst_q       <= det_rst_d;
    end
  end

  assign det_din       = det_din_q;
  assign det_rst       = det_rst_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign hit_count     = hit_count_q;
  assign first_hit_pos = first_hit_pos_q;
  assign hit_any       = hit_any_q;
  assign err_underrun  = err_underrun_q;

endmodule

// File: tb/tb_seqdetect_scan.sv
// Bench for seqdetect_scan: behavioural detector, scan table and result scoreboard.
module tb_seqdetect_scan;
  import seqdetect_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, word_valid;
  logic [7:0]  num_words, word_data;
  logic        word_ready, det_din, det_rst, busy, done, hit_any, err_underrun;
  logic [7:0]  hit_count;
  logic [10:0] first_hit_pos;
  logic        word_ready_s, det_din_s, det_rst_s, busy_s, done_s, hit_any_s, err_underrun_s;
  logic [1:0]  hit_count_s;
  logic [10:0] first_hit_pos_s;
  logic        det_flag = 1'b0;
  logic [7:0]  dsr = 8'h00;
  logic        dm_prev = 1'b0;
  logic [7:0]  dwin;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seqdetect_scan dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .det_din(det_din), .det_rst(det_rst),
    .det_flag(det_flag), .busy(busy), .done(done), .hit_count(hit_count),
    .first_hit_pos(first_hit_pos), .hit_any(hit_any), .err_underrun(err_underrun)
  );

  // Same stimulus, narrow counter: only the saturation behaviour differs.
  seqdetect_scan #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready_s), .det_din(det_din_s),
    .det_rst(det_rst_s), .det_flag(det_flag), .busy(busy_s), .done(done_s),
    .hit_count(hit_count_s), .first_hit_pos(first_hit_pos_s), .hit_any(hit_any_s),
    .err_underrun(err_underrun_s)
  );

  // Detector model: registered flag, high for two cycles after the matching bit.
  assign dwin = {dsr[6:0], det_din};
  always @(posedge clk) begin
    if (det_rst) begin
      dsr <= 8'h00; dm_prev <= 1'b0; det_flag <= 1'b0;
    end else begin
      dsr      <= dwin;
      dm_prev  <= (dwin == SEQ_PATTERN);
      det_flag <= (dwin == SEQ_PATTERN) | dm_prev;
    end
  end

  typedef struct {
    int          n, avail, delay;
    logic [39:0] ws;
    int          cnt, sat, pos;
    int          any, und, poke;
  } vec_t;

  typedef struct {
    int cnt, sat, pos, any, und, done_cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int n, input int avail, input int delay,
                              input logic [39:0] ws, input int cnt, input int sat,
                              input int pos, input int any, input int und, input int poke);
    vec_t v;
    v.n = n; v.avail = avail; v.delay = delay; v.ws = ws;
    v.cnt = cnt; v.sat = sat; v.pos = pos; v.any = any; v.und = und; v.poke = poke;
    return v;
  endfunction

  // Scoreboard: every done pulse pops and checks the oldest expected scan.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("hit_count", 32'(hit_count), 32'(e.cnt));
        chk("hit_count_sat", 32'(hit_count_s), 32'(e.sat));
        chk("first_hit_pos", 32'(first_hit_pos), 32'(e.pos));
        chk("hit_any", 32'(hit_any), 32'(e.any));
        chk("err_underrun", 32'(err_underrun), 32'(e.und));
        chk("done_sat_aligned", 32'(done_s), 32'd1);
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_det_rst"}, 32'(det_rst), 32'd1);
    chk({tag, "_det_din"}, 32'(det_din), 32'd0);
    chk({tag, "_word_ready"}, 32'(word_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
    chk({tag, "_first_hit_pos"}, 32'(first_hit_pos), 32'd0);
    chk({tag, "_hit_any"}, 32'(hit_any), 32'd0);
    chk({tag, "_err_underrun"}, 32'(err_underrun), 32'd0);
  endtask

  task automatic run_scan(input vec_t v);
    int          c0, idx, m, lat;
    bit          seen;
    logic [63:0] mask, exp_mask;
    exp_t        e;
    @(negedge clk);
    c0   = cyc;
    m    = (v.avail < v.n) ? v.avail : v.n;
    lat  = (v.n == 0) ? 2 : 4 + 8 * m + v.delay;
    e.cnt = v.cnt; e.sat = v.sat; e.pos = v.pos; e.any = v.any; e.und = v.und;
    e.done_cyc = c0 + lat;
    sbq.push_back(e);
    idx = 0; mask = '0; seen = 0;
    for (int r = 0; r < 100 && !seen; r++) begin
      if (r > 0) @(negedge clk);
      start      = (r == 0) || (v.poke != 0 && r == 8);
      num_words  = (r == 0) ? 8'(v.n) : 8'd0;
      word_valid = (idx < v.avail) && (r >= 2 + v.delay);
      word_data  = (idx < 5) ? v.ws[39 - 8 * idx -: 8] : 8'h00;
      if (word_ready && r < 64) mask[r] = 1'b1;
      if (word_ready && word_valid) idx++;
      if (done) seen = 1;
    end
    start = 1'b0; word_valid = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    exp_mask = '0;
    if (v.n > 0) begin
      for (int k = 0; k <= v.delay; k++) exp_mask[2 + k] = 1'b1;
      for (int k = 0; k < m; k++) exp_mask[10 + v.delay + 8 * k] = 1'b1;
    end
    chk("ready_mask_lo", mask[31:0], exp_mask[31:0]);
    chk("ready_mask_hi", mask[63:32], exp_mask[63:32]);
    @(negedge clk);
    chk("hold_hit_count", 32'(hit_count), 32'(v.cnt));
    chk("hold_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //            n  av dly words           cnt sat pos any und poke
    vecs[0] = mk(1, 1, 0, 40'h3C00000000, 1, 1, 7,  1, 0, 0);
    vecs[1] = mk(2, 2, 0, 40'h03C0000000, 1, 1, 11, 1, 0, 0);
    vecs[2] = mk(3, 3, 0, 40'h3C3C3C0000, 3, 3, 7,  1, 0, 1);
    vecs[3] = mk(2, 1, 0, 40'h3C00000000, 1, 1, 7,  1, 1, 0);
    vecs[4] = mk(5, 5, 0, 40'h3C3C3C3C3C, 5, 3, 7,  1, 0, 0);
    vecs[5] = mk(0, 0, 0, 40'h0000000000, 0, 0, 0,  0, 0, 0);
    vecs[6] = mk(2, 2, 0, 40'hFF00000000, 0, 0, 0,  0, 0, 0);
    vecs[7] = mk(1, 1, 0, 40'h1E00000000, 0, 0, 0,  0, 0, 0);
    vecs[8] = mk(1, 1, 3, 40'h3C00000000, 1, 1, 7,  1, 0, 0);
    vecs[9] = mk(2, 2, 0, 40'h00F0000000, 1, 1, 13, 1, 0, 0);

    rst = 1'b1; start = 1'b0; num_words = 8'd0; word_data = 8'h00; word_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_scan(vecs[i]);

    // Reset in the middle of a three-word scan, after the first hit is counted.
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      if (r > 0) @(negedge clk);
      start      = (r == 0);
      num_words  = 8'd3;
      word_valid = 1'b1;
      word_data  = 8'h3C;
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_hit_count", 32'(hit_count), 32'd1);
    rst = 1'b1; start = 1'b0; word_valid = 1'b0;
    @(negedge clk);
    chk_reset_state("mid_rst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
